// File: rtl/reg_file_sb_pkg.sv
// Shared types and helpers for the reg_file_sb register file.
//   state_t          : clear-engine FSM states
//   ZERO_REG_DEFAULT : default for the hardwired-zero register 0 option
//   clog2()          : address width from register count
package reg_file_sb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam int ZERO_REG_DEFAULT = 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// Decode/writeback-facing bus of reg_file_sb.
//   master : pipeline side (drives addresses, write data, issue, clear request)
//   slave  : register file side (drives read data, busy flags, clear status)
interface reg_file_sb_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
);
  logic [AW-1:0]    ra;
  logic [AW-1:0]    rb;
  logic [AW-1:0]    rw;
  logic             regwr;
  logic [WIDTH-1:0] busw;
  logic [WIDTH-1:0] busa;
  logic [WIDTH-1:0] busb;
  logic             issuewr;
  logic [AW-1:0]    issuerd;
  logic             busya;
  logic             busyb;
  logic             clrreq;
  logic             clrbusy;

  modport master (
    output ra, rb, rw, regwr, busw, issuewr, issuerd, clrreq,
    input  busa, busb, busya, busyb, clrbusy
  );

  modport slave (
    input  ra, rb, rw, regwr, busw, issuewr, issuerd, clrreq,
    output busa, busb, busya, busyb, clrbusy
  );
endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// Per-register busy vector for hazard detection.
//   clk, rst_n         : clock, async active-low reset
//   flush              : zero every busy bit (highest priority)
//   set_en, set_idx    : mark a register as having an outstanding producer
//   clr_en, clr_idx    : producer has written back
//   rd_a, rd_b         : lookup addresses
//   busy_a, busy_b     : raw busy bits for the lookups
module reg_scoreboard #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          set_en,
  input  logic [AW-1:0] set_idx,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_idx,
  input  logic [AW-1:0] rd_a,
  input  logic [AW-1:0] rd_b,
  output logic          busy_a,
  output logic          busy_b
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // Set is applied after clear so a new producer wins over a retiring one.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_idx] = 1'b0;
    if (set_en) busy_d[set_idx] = 1'b1;
    if (flush)  busy_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_a = busy_q[rd_a];
  assign busy_b = busy_q[rd_b];

endmodule

// File: rtl/reg_file_sb.sv
// 2-read/1-write register file with write-through bypass, busy scoreboard
// and a sequential bulk-clear engine.
//   clk    : rising-edge clock
//   rst_n  : async active-low reset (clears storage, busy bits, FSM)
//   bus    : reg_file_sb_if slave (ra/rb/busa/busb reads, rw/regwr/busw write,
//            issuewr/issuerd scoreboard set, busya/busyb hazards,
//            clrreq/clrbusy bulk clear)
//
// state | meaning
// IDLE  | normal operation, writes and issues accepted
// CLEAR | sweeping mem[idx] to zero, one register per cycle
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = ZERO_REG_DEFAULT
) (
  input logic         clk,
  input logic         rst_n,
  reg_file_sb_if.slave bus
);

  localparam int            AW        = clog2(DEPTH);
  localparam bit            ZR        = (ZERO_REG != 0);
  localparam logic [AW-1:0] IDX_FIRST = ZR ? AW'(1) : '0;
  localparam logic [AW-1:0] IDX_LAST  = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  state_t           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic             flush;
  logic             idle;
  logic             wr_live;
  logic             wr_ok;
  logic             set_ok;
  logic             hit_a, hit_b;
  logic             zero_a, zero_b;
  logic             sb_a, sb_b;

  assign idle    = (state_q == IDLE);
  // wr_live drives the bypass; wr_ok additionally drops writes to hardwired r0.
  assign wr_live = bus.regwr && idle;
  assign wr_ok   = wr_live && !(ZR && bus.rw == '0);
  assign set_ok  = bus.issuewr && idle && !(ZR && bus.issuerd == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    flush   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.clrreq) begin
          state_d = CLEAR;
          idx_d   = IDX_FIRST;
          flush   = 1'b1;
        end
      end
      CLEAR: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (!idle) begin
      mem[idx_q] <= '0;
    end else if (wr_ok) begin
      mem[bus.rw] <= bus.busw;
    end
  end

  reg_scoreboard #(.DEPTH(DEPTH), .AW(AW)) u_scoreboard (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .set_en  (set_ok),
    .set_idx (bus.issuerd),
    .clr_en  (wr_ok),
    .clr_idx (bus.rw),
    .rd_a    (bus.ra),
    .rd_b    (bus.rb),
    .busy_a  (sb_a),
    .busy_b  (sb_b)
  );

  assign zero_a = ZR && (bus.ra == '0);
  assign zero_b = ZR && (bus.rb == '0);
  assign hit_a  = wr_live && (bus.rw == bus.ra);
  assign hit_b  = wr_live && (bus.rw == bus.rb);

  assign bus.busa    = zero_a ? '0 : (hit_a ? bus.busw : mem[bus.ra]);
  assign bus.busb    = zero_b ? '0 : (hit_b ? bus.busw : mem[bus.rb]);
  // A value being bypassed this cycle is already available, so it is no hazard.
  assign bus.busya   = sb_a && !hit_a && !zero_a;
  assign bus.busyb   = sb_b && !hit_b && !zero_b;
  assign bus.clrbusy = (state_q == CLEAR);

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;

  typedef struct {
    logic        wr;
    logic [4:0]  rw;
    logic [31:0] w;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        iw;
    logic [4:0]  ird;
    logic        clr;
    logic [31:0] ea;
    logic [31:0] eb;
    logic        eba;
    logic        ebb;
    logic        ecb;
  } row_t;

  typedef struct {
    string       tag;
    logic [31:0] a;
    logic [31:0] b;
    logic        ba;
    logic        bb;
    logic        cb;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  reg_file_sb_if #(.WIDTH(32), .AW(5)) ifa ();
  reg_file_sb_if #(.WIDTH(8),  .AW(4)) ifb ();

  reg_file_sb #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  reg_file_sb #(.WIDTH(8), .DEPTH(16), .ZERO_REG(0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  function automatic row_t mk(input logic wr, input logic [4:0] rw, input logic [31:0] w,
                              input logic [4:0] ra, input logic [4:0] rb,
                              input logic iw, input logic [4:0] ird, input logic clr,
                              input logic [31:0] ea, input logic [31:0] eb,
                              input logic eba, input logic ebb, input logic ecb);
    row_t r;
    r.wr = wr; r.rw = rw; r.w = w; r.ra = ra; r.rb = rb;
    r.iw = iw; r.ird = ird; r.clr = clr;
    r.ea = ea; r.eb = eb; r.eba = eba; r.ebb = ebb; r.ecb = ecb;
    return r;
  endfunction

  task automatic push_exp(input string tag, input row_t r);
    exp_t e;
    e.tag = tag; e.a = r.ea; e.b = r.eb; e.ba = r.eba; e.bb = r.ebb; e.cb = r.ecb;
    exp_q.push_back(e);
  endtask

  task automatic apply_a(input string tag, input row_t r);
    ifa.regwr = r.wr; ifa.rw = r.rw; ifa.busw = r.w; ifa.ra = r.ra; ifa.rb = r.rb;
    ifa.issuewr = r.iw; ifa.issuerd = r.ird; ifa.clrreq = r.clr;
    push_exp(tag, r);
  endtask

  task automatic apply_b(input string tag, input row_t r);
    logic [4:0] t;
    ifb.regwr = r.wr; t = r.rw; ifb.rw = t[3:0]; ifb.busw = r.w[7:0];
    t = r.ra; ifb.ra = t[3:0]; t = r.rb; ifb.rb = t[3:0];
    ifb.issuewr = r.iw; t = r.ird; ifb.issuerd = t[3:0]; ifb.clrreq = r.clr;
    push_exp(tag, r);
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    apply_a("reset_a", mk(0, 0, 0, 5, 3, 0, 0, 0, 0, 0, 0, 0, 0));
    apply_b("reset_b_unused", mk(0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0));
    void'(exp_q.pop_back());
    @(negedge clk);
    #2;
    e = exp_q.pop_front();
    checks++;
    if ({ifa.busa, ifa.busb, ifa.busya, ifa.busyb, ifa.clrbusy} !== {e.a, e.b, e.ba, e.bb, e.cb}) begin
      errors++;
      $display("FAIL %s: got a=%h b=%h busya=%b busyb=%b clrbusy=%b, want a=%h b=%h busya=%b busyb=%b clrbusy=%b",
               e.tag, ifa.busa, ifa.busb, ifa.busya, ifa.busyb, ifa.clrbusy, e.a, e.b, e.ba, e.bb, e.cb);
    end
    checks++;
    if ({ifb.busa, ifb.busb, ifb.busya, ifb.busyb, ifb.clrbusy} !== 19'd0) begin
      errors++;
      $display("FAIL reset_b: got a=%h b=%h busya=%b busyb=%b clrbusy=%b, want all zero",
               ifb.busa, ifb.busb, ifb.busya, ifb.busyb, ifb.clrbusy);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    row_t t[4];
    exp_t e;
    t = '{mk(1, 5, 32'h1234, 5, 0, 0, 0, 0, 32'h1234, 0,        0, 0, 0),
          mk(0, 0, 0,        5, 5, 0, 0, 0, 32'h1234, 32'h1234, 0, 0, 0),
          mk(1, 0, 32'hFFFF, 0, 5, 0, 0, 0, 0,        32'h1234, 0, 0, 0),
          mk(0, 0, 0,        0, 5, 0, 0, 0, 0,        32'h1234, 0, 0, 0)};
    foreach (t[i]) begin
      @(negedge clk);
      apply_a($sformatf("write_read%0d", i), t[i]);
      #2;
      e = exp_q.pop_front();
      checks++;
      if ({ifa.busa, ifa.busb, ifa.busya, ifa.busyb, ifa.clrbusy} !== {e.a, e.b, e.ba, e.bb, e.cb}) begin
        errors++;
        $display("FAIL %s: got a=%h b=%h busya=%b busyb=%b clrbusy=%b, want a=%h b=%h busya=%b busyb=%b clrbusy=%b",
                 e.tag, ifa.busa, ifa.busb, ifa.busya, ifa.busyb, ifa.clrbusy, e.a, e.b, e.ba, e.bb, e.cb);
      end
    end
  endtask

  task automatic test_bypass();
    row_t t[4];
    exp_t e;
    t = '{mk(0, 0, 0,        7, 7, 1, 7, 0, 0,        0,        0, 0, 0),
          mk(0, 0, 0,        7, 7, 0, 0, 0, 0,        0,        1, 1, 0),
          mk(1, 7, 32'hA5A5, 7, 7, 0, 0, 0, 32'hA5A5, 32'hA5A5, 0, 0, 0),
          mk(0, 0, 0,        7, 5, 0, 0, 0, 32'hA5A5, 32'h1234, 0, 0, 0)};
    foreach (t[i]) begin
      @(negedge clk);
      apply_a($sformatf("bypass%0d", i), t[i]);
      #2;
      e = exp_q.pop_front();
      checks++;
      if ({ifa.busa, ifa.busb, ifa.busya, ifa.busyb, ifa.clrbusy} !== {e.a, e.b, e.ba, e.bb, e.cb}) begin
        errors++;
        $display("FAIL %s: got a=%h b=%h busya=%b busyb=%b clrbusy=%b, want a=%h b=%h busya=%b busyb=%b clrbusy=%b",
                 e.tag, ifa.busa, ifa.busb, ifa.busya, ifa.busyb, ifa.clrbusy, e.a, e.b, e.ba, e.bb, e.cb);
      end
    end
  endtask

  task automatic test_scoreboard();
    row_t t[9];
    exp_t e;
    t = '{mk(0, 0, 0,      3, 0, 1, 3, 0, 0,      0,      0, 0, 0),
          mk(0, 0, 0,      3, 0, 0, 0, 0, 0,      0,      1, 0, 0),
          mk(1, 3, 32'h33, 3, 3, 0, 0, 0, 32'h33, 32'h33, 0, 0, 0),
          mk(0, 0, 0,      3, 0, 0, 0, 0, 32'h33, 0,      0, 0, 0),
          mk(0, 0, 0,      3, 0, 1, 3, 0, 32'h33, 0,      0, 0, 0),
          mk(1, 3, 32'h44, 3, 4, 1, 3, 0, 32'h44, 0,      0, 0, 0),
          mk(0, 0, 0,      3, 3, 0, 0, 0, 32'h44, 32'h44, 1, 1, 0),
          mk(1, 3, 32'h55, 3, 0, 1, 0, 0, 32'h55, 0,      0, 0, 0),
          mk(0, 0, 0,      3, 0, 0, 0, 0, 32'h55, 0,      0, 0, 0)};
    foreach (t[i]) begin
      @(negedge clk);
      apply_a($sformatf("scoreboard%0d", i), t[i]);
      #2;
      e = exp_q.pop_front();
      checks++;
      if ({ifa.busa, ifa.busb, ifa.busya, ifa.busyb, ifa.clrbusy} !== {e.a, e.b, e.ba, e.bb, e.cb}) begin
        errors++;
        $display("FAIL %s: got a=%h b=%h busya=%b busyb=%b clrbusy=%b, want a=%h b=%h busya=%b busyb=%b clrbusy=%b",
                 e.tag, ifa.busa, ifa.busb, ifa.busya, ifa.busyb, ifa.clrbusy, e.a, e.b, e.ba, e.bb, e.cb);
      end
    end
  endtask

  // Builds the stimulus row for one cycle of the clear scenario.
  function automatic row_t clear_row(input int step);
    logic [4:0] i5;
    int k;
    if (step < 31) begin
      i5 = 5'(step + 1);
      return mk(1, i5, 32'(step + 1), i5, 0, 0, 0, 0, 32'(step + 1), 0, 0, 0, 0);
    end
    if (step == 31) return mk(0, 0, 0, 2, 31, 1, 2, 0, 2, 31, 0, 0, 0);
    if (step == 32) return mk(0, 0, 0, 2, 9,  0, 0, 1, 2, 9,  1, 0, 0);
    if (step < 64) begin
      k = step - 33;
      return mk(k == 20, 9, 32'hFF, 9, 20, k == 5, 6, k < 3,
                (k <= 8) ? 32'd9 : 32'd0, (k <= 19) ? 32'd20 : 32'd0, 0, 0, 1);
    end
    if (step == 64) return mk(0, 0, 0, 9, 6, 0, 0, 0, 0, 0, 0, 0, 0);
    i5 = 5'(step - 65);
    return mk(0, 0, 0, i5, ~i5, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic test_clear();
    exp_t e;
    for (int s = 0; s < 97; s++) begin
      @(negedge clk);
      apply_a($sformatf("clear_step%0d", s), clear_row(s));
      #2;
      e = exp_q.pop_front();
      checks++;
      if ({ifa.busa, ifa.busb, ifa.busya, ifa.busyb, ifa.clrbusy} !== {e.a, e.b, e.ba, e.bb, e.cb}) begin
        errors++;
        $display("FAIL %s: got a=%h b=%h busya=%b busyb=%b clrbusy=%b, want a=%h b=%h busya=%b busyb=%b clrbusy=%b",
                 e.tag, ifa.busa, ifa.busb, ifa.busya, ifa.busyb, ifa.clrbusy, e.a, e.b, e.ba, e.bb, e.cb);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    exp_t e;
    row_t r;
    for (int s = 0; s < 17; s++) begin
      @(negedge clk);
      case (s)
        0:       r = mk(1, 30, 32'h30, 30, 0, 0, 0,  0, 32'h30, 0, 0, 0, 0);
        1:       r = mk(0, 0,  0,      0,  0, 1, 30, 0, 0,      0, 0, 0, 0);
        2:       r = mk(0, 0,  0,      30, 0, 0, 0,  0, 32'h30, 0, 1, 0, 0);
        3:       r = mk(0, 0,  0,      30, 0, 0, 0,  1, 32'h30, 0, 1, 0, 0);
        14:      r = mk(0, 0,  0,      30, 0, 0, 0,  0, 0,      0, 0, 0, 0);
        15, 16:  r = mk(0, 0,  0,      30, 4, 0, 0,  0, 0,      0, 0, 0, 0);
        default: r = mk(0, 0,  0,      30, 0, 0, 0,  0, 32'h30, 0, 0, 0, 1);
      endcase
      if (s == 14) rst_n = 1'b0;
      if (s == 15) rst_n = 1'b1;
      apply_a($sformatf("rst_mid_clear%0d", s), r);
      #2;
      e = exp_q.pop_front();
      checks++;
      if ({ifa.busa, ifa.busb, ifa.busya, ifa.busyb, ifa.clrbusy} !== {e.a, e.b, e.ba, e.bb, e.cb}) begin
        errors++;
        $display("FAIL %s: got a=%h b=%h busya=%b busyb=%b clrbusy=%b, want a=%h b=%h busya=%b busyb=%b clrbusy=%b",
                 e.tag, ifa.busa, ifa.busb, ifa.busya, ifa.busyb, ifa.clrbusy, e.a, e.b, e.ba, e.bb, e.cb);
      end
    end
  endtask

  task automatic test_zero_reg0();
    exp_t e;
    row_t r;
    for (int s = 0; s < 23; s++) begin
      @(negedge clk);
      case (s)
        0:       r = mk(1, 0, 32'h5A, 0, 1, 0, 0, 0, 32'h5A, 0, 0, 0, 0);
        1:       r = mk(0, 0, 0,      0, 0, 0, 0, 0, 32'h5A, 32'h5A, 0, 0, 0);
        2:       r = mk(0, 0, 0,      0, 1, 1, 0, 0, 32'h5A, 0, 0, 0, 0);
        3:       r = mk(0, 0, 0,      0, 1, 0, 0, 1, 32'h5A, 0, 1, 0, 0);
        20:      r = mk(0, 0, 0,      0, 15, 0, 0, 0, 0, 0, 0, 0, 0);
        21, 22:  r = mk(0, 0, 0,      0, 15, 0, 0, 0, 0, 0, 0, 0, 0);
        default: r = mk(0, 0, 0,      0, 15, 0, 0, 0, (s == 4) ? 32'h5A : 32'h0, 0, 0, 0, 1);
      endcase
      apply_b($sformatf("zero_reg0_%0d", s), r);
      #2;
      e = exp_q.pop_front();
      checks++;
      if ({ifb.busa, ifb.busb, ifb.busya, ifb.busyb, ifb.clrbusy} !== {e.a[7:0], e.b[7:0], e.ba, e.bb, e.cb}) begin
        errors++;
        $display("FAIL %s: got a=%h b=%h busya=%b busyb=%b clrbusy=%b, want a=%h b=%h busya=%b busyb=%b clrbusy=%b",
                 e.tag, ifb.busa, ifb.busb, ifb.busya, ifb.busyb, ifb.clrbusy, e.a[7:0], e.b[7:0], e.ba, e.bb, e.cb);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    ifa.regwr = 0; ifa.rw = 0; ifa.busw = 0; ifa.ra = 0; ifa.rb = 0;
    ifa.issuewr = 0; ifa.issuerd = 0; ifa.clrreq = 0;
    ifb.regwr = 0; ifb.rw = 0; ifb.busw = 0; ifb.ra = 0; ifb.rb = 0;
    ifb.issuewr = 0; ifb.issuerd = 0; ifb.clrreq = 0;
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_clear();
    test_reset_mid_clear();
    test_zero_reg0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
